// File: rtl/status_reg_requester.sv
// Initiator front end for the status register file: tags commands, issues them, captures read results.
// Optional SRF_REQ_WRITE_ACK_EN: writes also return a response and o_rsp_is_write is added.
module status_reg_requester #(
    parameter int WORD_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int TAG_WIDTH  = 2,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [WORD_WIDTH-1:0] i_req_data,
    output logic [TAG_WIDTH-1:0]  o_rf_tag,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [WORD_WIDTH-1:0] o_rf_data,
    output logic                  o_rf_wen,
    output logic                  o_rf_valid,
    output logic                  o_rf_halt,
    input  logic                  i_rf_freeze,
    input  logic [TAG_WIDTH-1:0]  i_rf_tag,
    input  logic [WORD_WIDTH-1:0] i_rf_data,
    input  logic                  i_rf_data_init,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [TAG_WIDTH-1:0]  o_rsp_tag,
    output logic [WORD_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_init,
    output logic                  o_rsp_err,
    output logic                  o_idle
`ifdef SRF_REQ_WRITE_ACK_EN
    ,
    output logic                  o_rsp_is_write
`endif
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    logic                 issue_accept;
    logic                 req_fire;
    logic [TAG_WIDTH-1:0] tag_cnt_reg;
    logic                 pending_reg;
    logic [TAG_WIDTH-1:0] exp_tag_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W:0]       occupancy;
    logic                 push;
    logic                 pop;

    logic [TAG_WIDTH-1:0]  tag_mem  [RSP_DEPTH];
    logic [WORD_WIDTH-1:0] data_mem [RSP_DEPTH];
    logic                  init_mem [RSP_DEPTH];
    logic                  err_mem  [RSP_DEPTH];

    assign issue_accept = o_rf_valid & ~i_rf_freeze;
    assign o_req_ready  = ~o_rf_valid | issue_accept;
    assign req_fire     = i_req_valid & o_req_ready;

    // Pending capture counts as occupied so a response never arrives without a free slot.
    assign occupancy = {1'b0, count_reg} + (CNT_W + 1)'(pending_reg);
    assign o_rf_halt = (occupancy >= DEPTH_C);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_rf_valid  <= 1'b0;
            o_rf_tag    <= '0;
            o_rf_addr   <= '0;
            o_rf_data   <= '0;
            o_rf_wen    <= 1'b0;
            tag_cnt_reg <= '0;
        end else if (req_fire) begin
            o_rf_valid  <= 1'b1;
            o_rf_tag    <= tag_cnt_reg;
            o_rf_addr   <= i_req_addr;
            o_rf_data   <= i_req_data;
            o_rf_wen    <= i_req_wen;
            tag_cnt_reg <= tag_cnt_reg + TAG_WIDTH'(1);
        end else if (issue_accept) begin
            o_rf_valid  <= 1'b0;
        end
    end

`ifdef SRF_REQ_WRITE_ACK_EN
    logic pending_wr_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_reg    <= 1'b0;
            pending_wr_reg <= 1'b0;
            exp_tag_reg    <= '0;
        end else begin
            pending_reg    <= issue_accept;
            pending_wr_reg <= issue_accept & o_rf_wen;
            if (issue_accept) exp_tag_reg <= o_rf_tag;
        end
    end
`else
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending_reg <= 1'b0;
            exp_tag_reg <= '0;
        end else begin
            pending_reg <= issue_accept & ~o_rf_wen;
            if (issue_accept) exp_tag_reg <= o_rf_tag;
        end
    end
`endif

    // The register file answers exactly one cycle after accepting, so capture needs no qualifier.
    assign push = pending_reg;
    assign pop  = o_rsp_valid & i_rsp_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    tag_mem[gi] <= i_rf_tag;
                    err_mem[gi] <= (i_rf_tag != exp_tag_reg);
`ifdef SRF_REQ_WRITE_ACK_EN
                    data_mem[gi] <= pending_wr_reg ? '0 : i_rf_data;
                    init_mem[gi] <= pending_wr_reg ? 1'b0 : i_rf_data_init;
`else
                    data_mem[gi] <= i_rf_data;
                    init_mem[gi] <= i_rf_data_init;
`endif
                end
            end
        end
    endgenerate

`ifdef SRF_REQ_WRITE_ACK_EN
    logic wr_mem [RSP_DEPTH];

    always_ff @(posedge clk) begin
        if (push) wr_mem[wr_ptr_reg] <= pending_wr_reg;
    end

    assign o_rsp_is_write = o_rsp_valid ? wr_mem[rd_ptr_reg] : 1'b0;
`endif

    // Head fields are masked while empty so the response bus reads as zero.
    assign o_rsp_valid = (count_reg != '0);
    assign o_rsp_tag   = o_rsp_valid ? tag_mem[rd_ptr_reg]  : '0;
    assign o_rsp_data  = o_rsp_valid ? data_mem[rd_ptr_reg] : '0;
    assign o_rsp_init  = o_rsp_valid ? init_mem[rd_ptr_reg] : 1'b0;
    assign o_rsp_err   = o_rsp_valid ? err_mem[rd_ptr_reg]  : 1'b0;

    assign o_idle = ~o_rf_valid & ~pending_reg & ~o_rsp_valid;

endmodule

// File: tb/tb_status_reg_requester.sv
// Randomized bench for status_reg_requester with a behavioural register file and response scoreboard.
module tb_status_reg_requester;

    localparam int WW    = 12;
    localparam int AW    = 3;
    localparam int TW    = 2;
    localparam int DEPTH = 2;
    localparam int NTAGS = 1 << TW;
    localparam int NADDR = 1 << AW;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic [TW-1:0] tag;
        logic          corrupt;
    } cmd_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [WW-1:0] data;
        logic          init;
        logic          err;
        logic          wr;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          i_req_wen = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [WW-1:0] i_req_data = '0;
    logic          i_rsp_ready = 1'b0;
    logic          extra_freeze = 1'b0;
    logic          corrupt_sel = 1'b0;
    logic          o_req_ready;
    logic [TW-1:0] o_rf_tag;
    logic [AW-1:0] o_rf_addr;
    logic [WW-1:0] o_rf_data;
    logic          o_rf_wen, o_rf_valid, o_rf_halt;
    logic          rf_freeze;
    logic [TW-1:0] rf_o_tag = '0;
    logic [WW-1:0] rf_o_data = '0;
    logic          rf_o_init = 1'b0;
    logic          o_rsp_valid, o_rsp_init, o_rsp_err, o_idle;
    logic [TW-1:0] o_rsp_tag;
    logic [WW-1:0] o_rsp_data;
`ifdef SRF_REQ_WRITE_ACK_EN
    logic          o_rsp_is_write;
`endif

    always #5 clk = ~clk;

    // The register file freezes its inputs whenever halted, plus random extra stalls.
    assign rf_freeze = o_rf_halt | extra_freeze;

    status_reg_requester #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wen(i_req_wen), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_rf_tag(o_rf_tag), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
        .o_rf_wen(o_rf_wen), .o_rf_valid(o_rf_valid), .o_rf_halt(o_rf_halt),
        .i_rf_freeze(rf_freeze), .i_rf_tag(rf_o_tag), .i_rf_data(rf_o_data),
        .i_rf_data_init(rf_o_init),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_tag(o_rsp_tag), .o_rsp_data(o_rsp_data),
        .o_rsp_init(o_rsp_init), .o_rsp_err(o_rsp_err),
        .o_idle(o_idle)
`ifdef SRF_REQ_WRITE_ACK_EN
        , .o_rsp_is_write(o_rsp_is_write)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model state: commands issued but not yet taken by the register file, responses owed.
    cmd_t          cmdq[$];
    exp_t          expq[$];
    logic [TW-1:0] popped_tags[$];
    int            visible = 0;
    bit            cap_due = 1'b0;
    bit            acc_due = 1'b0;
    int            tb_tag = 0;
    int            n_err_seen = 0;
    logic [WW-1:0] last_rsp_data = '0;
    logic [WW-1:0] ref_mem [NADDR] = '{default: '0};
    logic          ref_init[NADDR] = '{default: 1'b0};
    logic [WW-1:0] rf_mem  [NADDR] = '{default: '0};
    logic          rf_init [NADDR] = '{default: 1'b0};
    bit            st_load = 1'b0;
    logic [TW-1:0] st_tag = '0;
    logic [WW-1:0] st_data = '0;
    logic          st_init = 1'b0;

    always @(posedge clk) begin
        if (st_load) begin
            rf_o_tag  <= st_tag;
            rf_o_data <= st_data;
            rf_o_init <= st_init;
        end
    end

    always @(negedge clk) begin
        cmd_t c;
        exp_t e;
        st_load = 1'b0;
        if (!arst_n) begin
            cmdq.delete();
            expq.delete();
            visible = 0;
            cap_due = 1'b0;
            acc_due = 1'b0;
            tb_tag  = 0;
        end else begin
            visible += int'(cap_due);
            cap_due = acc_due;
            acc_due = 1'b0;
            check("halt", 32'(o_rf_halt), 32'(visible + int'(cap_due) >= DEPTH));
            check("no_overflow", 32'(visible + int'(cap_due) <= DEPTH), 32'(1));
            check("rf_valid", 32'(o_rf_valid), 32'(cmdq.size() != 0));
            check("req_ready", 32'(o_req_ready), 32'(cmdq.size() == 0 || !rf_freeze));
            check("rsp_valid", 32'(o_rsp_valid), 32'(visible > 0));
            check("idle", 32'(o_idle), 32'(cmdq.size() == 0 && visible == 0 && !cap_due));

            if (o_rsp_valid && i_rsp_ready) begin
                if (expq.size() == 0) begin
                    check("rsp_unexpected", 32'(expq.size()), 32'(1));
                end else begin
                    e = expq.pop_front();
                    check("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
                    check("rsp_data", 32'(o_rsp_data), 32'(e.data));
                    check("rsp_init", 32'(o_rsp_init), 32'(e.init));
                    check("rsp_err", 32'(o_rsp_err), 32'(e.err));
`ifdef SRF_REQ_WRITE_ACK_EN
                    check("rsp_is_write", 32'(o_rsp_is_write), 32'(e.wr));
`endif
                    $display("rsp tag=%0d data=%03h init=%0d err=%0d", o_rsp_tag, o_rsp_data,
                             o_rsp_init, o_rsp_err);
                end
                popped_tags.push_back(o_rsp_tag);
                last_rsp_data = o_rsp_data;
                if (o_rsp_err) n_err_seen++;
                visible--;
            end

            if (o_rf_valid && !rf_freeze) begin
                if (cmdq.size() == 0) begin
                    check("rf_spurious", 32'(cmdq.size()), 32'(1));
                end else begin
                    c = cmdq.pop_front();
                    check("rf_tag", 32'(o_rf_tag), 32'(c.tag));
                    check("rf_addr", 32'(o_rf_addr), 32'(c.addr));
                    check("rf_wen", 32'(o_rf_wen), 32'(c.wen));
                    if (c.wen) check("rf_data", 32'(o_rf_data), 32'(c.data));
                    st_load = 1'b1;
                    st_tag  = c.tag ^ TW'(c.corrupt);
                    st_data = rf_mem[c.addr];
                    st_init = rf_init[c.addr];
                    if (c.wen) begin
                        rf_mem[c.addr]  = c.data;
                        rf_init[c.addr] = 1'b1;
                    end
`ifdef SRF_REQ_WRITE_ACK_EN
                    acc_due = 1'b1;
`else
                    acc_due = !c.wen;
`endif
                end
            end

            if (i_req_valid && o_req_ready) begin
                c.wen     = i_req_wen;
                c.addr    = i_req_addr;
                c.data    = i_req_data;
                c.tag     = TW'(tb_tag);
                c.corrupt = corrupt_sel;
                tb_tag    = (tb_tag + 1) % NTAGS;
                cmdq.push_back(c);
                e.tag = c.tag ^ TW'(c.corrupt);
                e.err = c.corrupt;
                if (!c.wen) begin
                    e.data = ref_mem[c.addr];
                    e.init = ref_init[c.addr];
                    e.wr   = 1'b0;
                    expq.push_back(e);
                end else begin
                    ref_mem[c.addr]  = c.data;
                    ref_init[c.addr] = 1'b1;
`ifdef SRF_REQ_WRITE_ACK_EN
                    e.data = '0;
                    e.init = 1'b0;
                    e.wr   = 1'b1;
                    expq.push_back(e);
`endif
                end
            end
        end
    end

    // Tasks start and end just after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic wen, input logic [AW-1:0] addr, input logic [WW-1:0] data,
                         input logic corrupt);
        bit ok = 1'b0;
        i_req_valid = 1'b1;
        i_req_wen   = wen;
        i_req_addr  = addr;
        i_req_data  = data;
        corrupt_sel = corrupt;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_timeout", 32'(ok), 32'(1));
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        corrupt_sel = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        check("rst_rf_valid", 32'(o_rf_valid), 32'(0));
        check("rst_rf_tag", 32'(o_rf_tag), 32'(0));
        check("rst_rf_addr", 32'(o_rf_addr), 32'(0));
        check("rst_rf_data", 32'(o_rf_data), 32'(0));
        check("rst_rf_wen", 32'(o_rf_wen), 32'(0));
        check("rst_halt", 32'(o_rf_halt), 32'(0));
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
        check("rst_rsp_tag", 32'(o_rsp_tag), 32'(0));
        check("rst_rsp_data", 32'(o_rsp_data), 32'(0));
        check("rst_rsp_init", 32'(o_rsp_init), 32'(0));
        check("rst_rsp_err", 32'(o_rsp_err), 32'(0));
        check("rst_idle", 32'(o_idle), 32'(1));
`ifdef SRF_REQ_WRITE_ACK_EN
        check("rst_rsp_is_write", 32'(o_rsp_is_write), 32'(0));
`endif
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        i_rsp_ready  = 1'b1;
        extra_freeze = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (o_idle && expq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 32'(done), 32'(1));
    endtask

    initial begin
        int base;
        int errs0;
        bit rand_run;

        #2;
        do_reset();

        // Unwritten read: response visible just after the second edge following the handshake.
        i_rsp_ready = 1'b1;
        issue(1'b0, AW'(5), '0, 1'b0);
        check("lat_e0", 32'(o_rsp_valid), 32'(0));
        idle(1);
        check("lat_e1", 32'(o_rsp_valid), 32'(0));
        idle(1);
        check("lat_e2", 32'(o_rsp_valid), 32'(1));
        check("lat_tag", 32'(o_rsp_tag), 32'(0));
        check("lat_init", 32'(o_rsp_init), 32'(0));
        check("lat_err", 32'(o_rsp_err), 32'(0));
        wait_drain();

        // Write then read back.
        do_reset();
        issue(1'b1, AW'(3), WW'(12'hABC), 1'b0);
        issue(1'b0, AW'(3), '0, 1'b0);
        wait_drain();
        check("wr_rd_tag", 32'(popped_tags[popped_tags.size() - 1]), 32'(1));
        check("wr_rd_data", 32'(last_rsp_data), 32'(12'hABC));

        // Eight back-to-back reads against a stalled consumer.
        do_reset();
        i_rsp_ready = 1'b0;
        base = popped_tags.size();
        fork
            begin
                for (int a = 0; a < 8; a++) issue(1'b0, AW'(a), '0, 1'b0);
            end
            begin
                idle(12);
                check("b2b_halt", 32'(o_rf_halt), 32'(1));
                check("b2b_slot", 32'(o_rf_valid), 32'(1));
                check("b2b_held", 32'(o_rsp_valid), 32'(1));
                i_rsp_ready = 1'b1;
            end
        join
        wait_drain();
        check("b2b_count", 32'(popped_tags.size() - base), 32'(8));
        for (int i = 0; i < 8 && base + i < popped_tags.size(); i++)
            check("b2b_tag_order", 32'(popped_tags[base + i]), 32'(i % NTAGS));

        // One corrupted register-file tag among three reads.
        errs0 = n_err_seen;
        issue(1'b0, AW'(3), '0, 1'b0);
        issue(1'b0, AW'(3), '0, 1'b1);
        issue(1'b0, AW'(2), '0, 1'b0);
        wait_drain();
        check("err_count", 32'(n_err_seen - errs0), 32'(1));

        // Streaming reads with the consumer always ready: concurrent push and pop.
        for (int a = 0; a < 6; a++) issue(1'b0, AW'(a), '0, 1'b0);
        wait_drain();

        // Asynchronous reset with a command parked and two responses queued.
        do_reset();
        i_rsp_ready = 1'b0;
        for (int a = 0; a < 3; a++) issue(1'b0, AW'(a + 1), '0, 1'b0);
        idle(3);
        check("mid_halt", 32'(o_rf_halt), 32'(1));
        check("mid_slot", 32'(o_rf_valid), 32'(1));
        check("mid_queued", 32'(o_rsp_valid), 32'(1));
        #2;
        do_reset();
        check("post_rst_idle", 32'(o_idle), 32'(1));
        issue(1'b0, AW'(1), '0, 1'b0);
        check("post_rst_tag", 32'(o_rf_tag), 32'(0));
        wait_drain();

        // Random traffic with random consumer back-pressure and register-file stalls.
        rand_run = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    issue(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, NADDR - 1)),
                          WW'($urandom), 1'($urandom_range(0, 7) == 0));
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    i_rsp_ready  = 1'($urandom_range(0, 3) != 0);
                    extra_freeze = 1'($urandom_range(0, 4) == 0);
                    idle(1);
                end
            end
        join
        wait_drain();
        check("leftover", 32'(expq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
